// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC control. Picks the PC source, gates the PC
// enable on fetch/memory/hazard stalls, holds a redirect that could not be
// applied in its arrival cycle, and freezes the PC once halted.
module pc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dwait,
  input  logic             hz_stall,
  input  logic             br_req,
  input  logic             j_req,
  input  logic             jr_req,
  input  logic             halt_req,
  output logic [1:0]       pc_src,
  output logic             pcEN,
  output logic             ifid_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, HOLD_REDIR, HALTED} state_t;

  localparam logic [1:0] SRC_SEQ = 2'b00;

  state_t     state;
  logic [1:0] redir_q;
  logic [1:0] code;
  logic       has_redir;
  logic       fire;
  logic       advance;

  // redirect priority jr > j > br; fire means fetch can take a new PC now
  always_comb begin
    code = SRC_SEQ;
    if (jr_req)      code = 2'b11;
    else if (j_req)  code = 2'b10;
    else if (br_req) code = 2'b01;
    has_redir = br_req | j_req | jr_req;
    fire      = ihit & ~dwait;
    advance   = fire & ~hz_stall;
  end

  // PC controls; a redirect ignores hz_stall since it squashes the stalled op
  always_comb begin
    pc_src     = SRC_SEQ;
    pcEN       = 1'b0;
    ifid_flush = 1'b0;
    if (nRST && !halt_req) begin
      unique case (state)
        RUN: begin
          if (has_redir) begin
            pc_src     = code;
            pcEN       = fire;
            ifid_flush = fire;
          end else begin
            pcEN = advance;
          end
        end
        HOLD_REDIR: begin
          // a fresh redirect in the apply cycle replaces the pending one
          pc_src     = (has_redir && fire) ? code : redir_q;
          pcEN       = fire;
          ifid_flush = fire;
        end
        default: ;
      endcase
    end
  end

  // state, pending redirect and halt flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      redir_q <= SRC_SEQ;
      halt    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_req) begin
            state   <= HALTED;
            halt    <= 1'b1;
            redir_q <= SRC_SEQ;
          end else if (has_redir && !fire) begin
            state   <= HOLD_REDIR;
            redir_q <= code;
          end
        end
        HOLD_REDIR: begin
          if (halt_req) begin
            state   <= HALTED;
            halt    <= 1'b1;
            redir_q <= SRC_SEQ;
          end else if (fire) begin
            state   <= RUN;
            redir_q <= SRC_SEQ;
          end else if (has_redir) begin
            redir_q <= code;
          end
        end
        default: begin
          state <= HALTED;
          halt  <= 1'b1;
        end
      endcase
    end
  end

  // saturating count of held-PC cycles, frozen once halted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (state != HALTED && !pcEN && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dwait, hz_stall, br_req, j_req, jr_req, halt_req;
  logic [1:0]  pc_src, pc_src_s;
  logic        pcEN, pcEN_s, ifid_flush, ifid_flush_s, halt, halt_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dwait(dwait), .hz_stall(hz_stall),
    .br_req(br_req), .j_req(j_req), .jr_req(jr_req), .halt_req(halt_req),
    .pc_src(pc_src), .pcEN(pcEN), .ifid_flush(ifid_flush), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  pc_sequencer #(.CNT_W(4)) dut_s (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dwait(dwait), .hz_stall(hz_stall),
    .br_req(br_req), .j_req(j_req), .jr_req(jr_req), .halt_req(halt_req),
    .pc_src(pc_src_s), .pcEN(pcEN_s), .ifid_flush(ifid_flush_s), .halt(halt_s),
    .stall_cnt(stall_cnt_s)
  );

  // apply one cycle of inputs {ihit,dwait,hz,br,j,jr,halt} and wait to sample
  task automatic drive(input logic [6:0] v);
    {ihit, dwait, hz_stall, br_req, j_req, jr_req, halt_req} = v;
    @(negedge CLK);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    {ihit, dwait, hz_stall, br_req, j_req, jr_req, halt_req} = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    // active request inputs must not leak through during reset
    {ihit, dwait, hz_stall, br_req, j_req, jr_req, halt_req} = 7'b1001000;
    #2;
    vecs++;
    if ({pc_src, pcEN, ifid_flush, halt, stall_cnt} !== {5'b00000, 16'd0}) begin
      errs++;
      $display("FAIL reset_outputs: got src=%b en=%b fl=%b h=%b cnt=%0d, want 00 0 0 0 0",
               pc_src, pcEN, ifid_flush, halt, stall_cnt);
    end
    @(posedge CLK);
    #1;
    {ihit, dwait, hz_stall, br_req, j_req, jr_req, halt_req} = '0;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(7'b1000000);
      vecs++;
      if ({pc_src, pcEN, ifid_flush, stall_cnt} !== {4'b0010, 16'd0}) begin
        errs++;
        $display("FAIL seq_fetch[%0d]: got src=%b en=%b fl=%b cnt=%0d, want 00 1 0 0",
                 i, pc_src, pcEN, ifid_flush, stall_cnt);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(7'b1001000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b0111) begin
      errs++;
      $display("FAIL br_apply: got src=%b en=%b fl=%b, want 01 1 1", pc_src, pcEN, ifid_flush);
    end
    tick();
    drive(7'b1000000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b0010) begin
      errs++;
      $display("FAIL br_after: got src=%b en=%b fl=%b, want 00 1 0", pc_src, pcEN, ifid_flush);
    end
    tick();
  endtask

  task automatic test_jump_miss();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i == 0 ? 7'b0000100 : 7'b0000000);
      vecs++;
      if ({pc_src, pcEN, ifid_flush} !== 4'b1000) begin
        errs++;
        $display("FAIL j_hold[%0d]: got src=%b en=%b fl=%b, want 10 0 0",
                 i, pc_src, pcEN, ifid_flush);
      end
      tick();
    end
    drive(7'b1000000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b1011) begin
      errs++;
      $display("FAIL j_apply: got src=%b en=%b fl=%b, want 10 1 1", pc_src, pcEN, ifid_flush);
    end
    tick();
    drive(7'b1000000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush, stall_cnt} !== {4'b0010, 16'd4}) begin
      errs++;
      $display("FAIL j_after: got src=%b en=%b fl=%b cnt=%0d, want 00 1 0 4",
               pc_src, pcEN, ifid_flush, stall_cnt);
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    drive(7'b1001110);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b1111) begin
      errs++;
      $display("FAIL prio_all: got src=%b en=%b fl=%b, want 11 1 1", pc_src, pcEN, ifid_flush);
    end
    tick();
    drive(7'b1001100);
    vecs++;
    if (pc_src !== 2'b10) begin
      errs++;
      $display("FAIL prio_j_br: got src=%b, want 10", pc_src);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    drive(7'b1010000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b0000) begin
      errs++;
      $display("FAIL hz_hold: got src=%b en=%b fl=%b, want 00 0 0", pc_src, pcEN, ifid_flush);
    end
    tick();
    // redirect squashes the hazard instruction
    drive(7'b1011000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b0111) begin
      errs++;
      $display("FAIL hz_redir: got src=%b en=%b fl=%b, want 01 1 1", pc_src, pcEN, ifid_flush);
    end
    tick();
    drive(7'b1000000);
    vecs++;
    if (stall_cnt !== 16'd1) begin
      errs++;
      $display("FAIL hz_cnt: got cnt=%0d, want 1", stall_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(7'b1101000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b0100) begin
      errs++;
      $display("FAIL b2b_br_hold: got src=%b en=%b fl=%b, want 01 0 0", pc_src, pcEN, ifid_flush);
    end
    tick();
    drive(7'b1100010);
    vecs++;
    if ({pcEN, ifid_flush} !== 2'b00) begin
      errs++;
      $display("FAIL b2b_jr_hold: got en=%b fl=%b, want 0 0", pcEN, ifid_flush);
    end
    tick();
    drive(7'b1000000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b1111) begin
      errs++;
      $display("FAIL b2b_apply: got src=%b en=%b fl=%b, want 11 1 1", pc_src, pcEN, ifid_flush);
    end
    tick();
    drive(7'b1000000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush} !== 4'b0010) begin
      errs++;
      $display("FAIL b2b_single_flush: got src=%b en=%b fl=%b, want 00 1 0",
               pc_src, pcEN, ifid_flush);
    end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    drive(7'b1101000);
    tick();
    drive(7'b1000001);
    vecs++;
    if ({pcEN, ifid_flush, halt} !== 3'b000) begin
      errs++;
      $display("FAIL halt_req_cycle: got en=%b fl=%b h=%b, want 0 0 0", pcEN, ifid_flush, halt);
    end
    tick();
    drive(7'b1000000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush, halt} !== 5'b00001) begin
      errs++;
      $display("FAIL halted: got src=%b en=%b fl=%b h=%b, want 00 0 0 1",
               pc_src, pcEN, ifid_flush, halt);
    end
    tick();
    drive(7'b1001000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush, halt} !== 5'b00001) begin
      errs++;
      $display("FAIL halted_br: got src=%b en=%b fl=%b h=%b, want 00 0 0 1",
               pc_src, pcEN, ifid_flush, halt);
    end
    tick();
    drive(7'b0000000);
    vecs++;
    if (stall_cnt !== 16'd2) begin
      errs++;
      $display("FAIL halted_cnt: got cnt=%0d, want 2", stall_cnt);
    end
    tick();
    do_reset();
    drive(7'b1000000);
    vecs++;
    if ({pc_src, pcEN, ifid_flush, halt, stall_cnt} !== {5'b00100, 16'd0}) begin
      errs++;
      $display("FAIL halt_cleared: got src=%b en=%b fl=%b h=%b cnt=%0d, want 00 1 0 0 0",
               pc_src, pcEN, ifid_flush, halt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(7'b0000000);
      tick();
    end
    drive(7'b0000000);
    vecs++;
    if (stall_cnt_s !== 4'd15) begin
      errs++;
      $display("FAIL sat_cnt4: got cnt=%0d, want 15", stall_cnt_s);
    end
    vecs++;
    if (stall_cnt !== 16'd20) begin
      errs++;
      $display("FAIL cnt16_20: got cnt=%0d, want 20", stall_cnt);
    end
    tick();
  endtask

  initial begin
    {ihit, dwait, hz_stall, br_req, j_req, jr_req, halt_req} = '0;
    nRST = 1'b1;
    #3;
    test_reset();
    test_branch();
    test_jump_miss();
    test_priority();
    test_stall();
    test_back_to_back();
    test_halt();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
